// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared defaults and entry record for the store buffer
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  // Entry fields are sized by the package defaults; AW/DW must not exceed them.
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core and data-memory signals of the store buffer
interface store_buffer_if
  import sb_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
);

  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wrdata;
  logic          cpu_memwrite;
  logic          cpu_memread;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          empty;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wrdata;
  logic          mem_memwrite;
  logic          mem_memread;
  logic [DW-1:0] mem_rdata;

  // master is the surrounding system: the core plus the data memory
  modport master (
    output cpu_addr, cpu_wrdata, cpu_memwrite, cpu_memread, mem_rdata,
    input  cpu_rdata, stall, empty, mem_addr, mem_wrdata, mem_memwrite, mem_memread
  );

  modport slave (
    input  cpu_addr, cpu_wrdata, cpu_memwrite, cpu_memread, mem_rdata,
    output cpu_rdata, stall, empty, mem_addr, mem_wrdata, mem_memwrite, mem_memread
  );

endinterface

// File: rtl/sb_match.sv
// rtl/sb_match.sv - youngest exact-match select and partial-overlap detect
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic [AW-1:0]            key,
  input  sb_entry_t                entries [DEPTH],
  input  logic [DEPTH-1:0]         valid,
  input  logic [$clog2(DEPTH)-1:0] head,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] hit_idx,
  output logic                     overlap
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;
  logic [AW-1:0] diff;

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    overlap = 1'b0;
    idx     = '0;
    diff    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx  = head + PW'(k);
      diff = key - AW'(entries[idx].addr);
      if (valid[idx] && (diff == '0)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
      if (valid[idx] && (diff != '0) &&
          ((diff < AW'(4)) || ((AW'(0) - diff) < AW'(4)))) begin
        overlap = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer with load bypass and hazard drain
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic           clk,
  input  logic           rst_n,
  store_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic          full;
  logic          hit;
  logic          overlap;
  logic [PW-1:0] hit_idx;
  logic          load_go;
  logic          push;
  logic          pop;
  sb_entry_t     head_e;

  sb_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .key     (bus.cpu_addr),
    .entries (entries),
    .valid   (valid),
    .head    (head),
    .hit     (hit),
    .hit_idx (hit_idx),
    .overlap (overlap)
  );

  assign full    = (count == CW'(DEPTH));
  assign head_e  = entries[head];

  // A load with a partial overlap is held while the buffer drains under it.
  assign load_go = rst_n && bus.cpu_memread && !overlap;
  assign pop     = rst_n && (count != '0) && !load_go;
  assign push    = bus.cpu_memwrite && !bus.stall;

  assign bus.stall        = rst_n && ((bus.cpu_memwrite && full) ||
                                      (bus.cpu_memread && overlap));
  assign bus.empty        = (count == '0);
  assign bus.mem_memread  = load_go;
  assign bus.mem_memwrite = pop;
  assign bus.mem_addr     = pop ? AW'(head_e.addr) : bus.cpu_addr;
  assign bus.mem_wrdata   = DW'(head_e.data);
  assign bus.cpu_rdata    = (bus.cpu_memread && hit) ? DW'(entries[hit_idx].data)
                                                     : bus.mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail].addr <= SB_AW'(bus.cpu_addr);
      entries[tail].data <= SB_DW'(bus.cpu_wrdata);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory: unwritten words read back as 0xD00000nn.
  logic [31:0]  mem [256];
  logic [255:0] wmask = '0;
  logic [31:0]  wlog_a [$];
  logic [31:0]  wlog_d [$];

  assign bus.mem_rdata = wmask[bus.mem_addr[7:0]] ? mem[bus.mem_addr[7:0]]
                                                  : {24'hD00000, bus.mem_addr[7:0]};

  always @(posedge clk) begin
    if (bus.mem_memwrite) begin
      mem[bus.mem_addr[7:0]]   <= bus.mem_wrdata;
      wmask[bus.mem_addr[7:0]] <= 1'b1;
      wlog_a.push_back(bus.mem_addr);
      wlog_d.push_back(bus.mem_wrdata);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_memwrite = we;
    bus.cpu_memread  = re;
    bus.cpu_addr     = a;
    bus.cpu_wrdata   = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 20 && !bus.empty; k++) tick();
    #2;
    chk(tag, 32'(bus.empty), 32'd1);
  endtask

  localparam logic [31:0] WRAP_EXP [6] = '{32'hC0DE0006, 32'hC0DE0007, 32'hC0DE0008,
                                           32'hC0DE0009, 32'hC0DE0004, 32'hC0DE0005};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b1, 32'h24, 32'h0);
    #2;
    chk("rst_empty",    32'(bus.empty),        32'd1);
    chk("rst_stall",    32'(bus.stall),        32'd0);
    chk("rst_memwrite", 32'(bus.mem_memwrite), 32'd0);
    chk("rst_memread",  32'(bus.mem_memread),  32'd0);
    chk("rst_rdata",    bus.cpu_rdata,         32'hD0000024);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("post_rst_memwrite", 32'(bus.mem_memwrite), 32'd0);
    tick();
    chk("post_rst_nowrite", 32'(wlog_a.size()), 32'd0);

    // three back-to-back stores drain in order
    drive(1'b1, 1'b0, 32'h10, 32'h11111111); #2;
    chk("seq_empty0", 32'(bus.empty), 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h20, 32'h22222222); #2;
    chk("seq_wr0_en",   32'(bus.mem_memwrite), 32'd1);
    chk("seq_wr0_addr", bus.mem_addr,   32'h10);
    chk("seq_wr0_data", bus.mem_wrdata, 32'h11111111);
    tick();
    drive(1'b1, 1'b0, 32'h30, 32'h33333333); #2;
    chk("seq_wr1_addr", bus.mem_addr, 32'h20);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0); #2;
    chk("seq_wr2_addr", bus.mem_addr, 32'h30);
    chk("seq_wr2_en",   32'(bus.mem_memwrite), 32'd1);
    tick(); #2;
    chk("seq_empty_end", 32'(bus.empty),        32'd1);
    chk("seq_idle_wr",   32'(bus.mem_memwrite), 32'd0);
    chk("seq_nwrites",   32'(wlog_a.size()),    32'd3);
    chk("seq_order2",    wlog_a[2],             32'h30);
    chk("seq_mem20",     mem[8'h20],            32'h22222222);

    // fill with loads every cycle, then a fifth store stalls
    b = wlog_a.size();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h40 + 32'(4 * i), 32'h40400000 + 32'(i)); #2;
      chk("full_fill_stall", 32'(bus.stall), 32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 32'h50, 32'h50505050); #2;
    chk("full_stall",    32'(bus.stall),        32'd1);
    chk("full_no_wr",    32'(bus.mem_memwrite), 32'd0);
    chk("full_load_go",  32'(bus.mem_memread),  32'd1);
    tick(); #2;
    chk("full_stall_hold", 32'(bus.stall), 32'd1);
    drive(1'b1, 1'b0, 32'h50, 32'h50505050); #2;
    chk("full_same_edge", 32'(bus.stall), 32'd1);
    chk("full_pop_addr",  bus.mem_addr,   32'h40);
    tick(); #2;
    chk("full_accept", 32'(bus.stall), 32'd0);
    tick();
    drain("full_drain");
    chk("full_nwrites", 32'(wlog_a.size() - b), 32'd5);
    chk("full_last",    wlog_a[b + 4],          32'h50);
    chk("full_last_d",  wlog_d[b + 4],          32'h50505050);

    // youngest match forwarding
    drive(1'b1, 1'b1, 32'h10, 32'hAAAA0001); #2;
    chk("fwd_miss", bus.cpu_rdata, 32'h11111111);
    tick();
    drive(1'b1, 1'b1, 32'h10, 32'hBBBB0002); #2;
    chk("fwd_preexist", bus.cpu_rdata, 32'hAAAA0001);
    tick();
    drive(1'b0, 1'b1, 32'h10, 32'h0); #2;
    chk("fwd_youngest", bus.cpu_rdata,         32'hBBBB0002);
    chk("fwd_memread",  32'(bus.mem_memread),  32'd1);
    chk("fwd_stall",    32'(bus.stall),        32'd0);
    tick();
    drain("fwd_drain");

    // partial overlap hazard
    drive(1'b1, 1'b1, 32'h12, 32'h12121212); #2;
    tick();
    drive(1'b0, 1'b1, 32'h10, 32'h0); #2;
    chk("haz_stall",    32'(bus.stall),        32'd1);
    chk("haz_no_read",  32'(bus.mem_memread),  32'd0);
    chk("haz_drain_wr", 32'(bus.mem_memwrite), 32'd1);
    chk("haz_drain_a",  bus.mem_addr,          32'h12);
    tick(); #2;
    chk("haz_release", 32'(bus.stall),       32'd0);
    chk("haz_read",    32'(bus.mem_memread), 32'd1);
    chk("haz_rdata",   bus.cpu_rdata,        32'hBBBB0002);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // reset discards buffered stores
    b = wlog_a.size();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h60 + 32'(4 * i), 32'h60600000 + 32'(i));
      tick();
    end
    #1 rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_mid_empty", 32'(bus.empty),        32'd1);
    chk("rst_mid_wr",    32'(bus.mem_memwrite), 32'd0);
    tick(); tick();
    #2 rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_mid_nowrite", 32'(wlog_a.size() - b), 32'd0);
    chk("rst_mid_mem60",   32'(wmask[8'h60]),      32'd0);

    // pointer wrap across interleaved store/drain cycles
    b = wlog_a.size();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 2) == 0, 32'h80 + 32'(4 * (i % 6)), 32'hC0DE0000 + 32'(i)); #2;
      chk("wrap_stall", 32'(bus.stall), 32'd0);
      tick();
      if (i % 2 == 1) begin
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
      end
    end
    drain("wrap_drain");
    chk("wrap_nwrites", 32'(wlog_a.size() - b), 32'd10);
    for (int j = 0; j < 6; j++) begin
      chk("wrap_mem", mem[8'h80 + 8'(4 * j)], WRAP_EXP[j]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of buffered stores (power of 2, min 2).
REQ-002 SHALL have parameter AW, 32, address width.
REQ-003 SHALL have parameter DW, 32, data width.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset: clk in 1, rst_n in 1; all state on rising clk.
REQ-005 SHALL have port cpu_addr  in  AW  core byte address.
REQ-006 SHALL have port cpu_wrdata  in  DW  core store data.
REQ-007 SHALL have port cpu_memwrite  in  1  core store request.
REQ-008 SHALL have port cpu_memread  in  1  core load request.
REQ-009 SHALL have port cpu_rdata  out  DW  load result to core.
REQ-010 SHALL have port stall  out  1  core must hold its current request.
REQ-011 SHALL have port empty  out  1  no buffered stores.
REQ-012 SHALL have port mem_addr  out  AW  data-memory address.
REQ-013 SHALL have port mem_wrdata  out  DW  data-memory write data.
REQ-014 SHALL have port mem_memwrite  out  1  data-memory write strobe.
REQ-015 SHALL have port mem_memread  out  1  data-memory read strobe.
REQ-016 SHALL have port mem_rdata  in  DW  data-memory combinational read data.

Function
REQ-017 SHALL hold an in-order queue of DEPTH entries {addr, data}, with head/tail pointers wrapping mod DEPTH and a count of 0..DEPTH.
REQ-018 SHALL enqueue {cpu_addr, cpu_wrdata} at the clk edge when cpu_memwrite=1 and stall=0.
REQ-019 SHALL assert stall when cpu_memwrite=1 and count==DEPTH; the same-edge dequeue does not free the slot for that cycle's store.
REQ-020 SHALL give loads priority on the memory port: with cpu_memread=1, mem_addr=cpu_addr, mem_memread=1, mem_memwrite=0, and no dequeue that cycle.
REQ-021 SHALL, with cpu_memread=0 and count>0, present the head entry: mem_addr=head.addr, mem_wrdata=head.data, mem_memwrite=1; the head is popped at that edge.
REQ-022 SHALL drive mem_memwrite=0, mem_memread=0 and mem_addr=cpu_addr when idle.
REQ-023 SHALL, when a load's cpu_addr exactly equals a valid entry's addr, return the youngest matching entry's data on cpu_rdata in the same cycle; otherwise cpu_rdata=mem_rdata.
REQ-024 SHALL treat a load overlapping any valid entry with 0<|cpu_addr-entry.addr|<4 as a hazard: assert stall, suppress mem_memread and drain one entry per cycle until no overlap remains, then service the load.
REQ-025 SHALL, when cpu_memread and cpu_memwrite are both 1, service the load against pre-existing entries only and enqueue the store at the same edge, subject to REQ-019/REQ-024.
REQ-026 SHALL drive empty = (count==0).
REQ-027 SHALL keep stall combinational, with zero added latency for loads without a hazard and one-cycle store acceptance.

Reset
REQ-028 SHALL, on rst_n=0, immediately clear count, head and tail, and invalidate all entries; pending stores are discarded.
REQ-029 SHALL hold these outputs during reset: stall=0, empty=1, mem_memwrite=0, mem_memread=0, cpu_rdata=mem_rdata.
REQ-030 SHALL not write memory on the first edge after rst_n deasserts unless a store was enqueued on a prior edge.

Structure
REQ-031 SHALL place DEPTH, AW, DW defaults and the entry record type in shared package sb_pkg.
REQ-032 SHALL implement youngest-match priority selection and overlap detection in sub-module sb_match (combinational, DEPTH-wide).

Verification
REQ-033 SHALL verify: stores to 0x10, 0x20, 0x30 on consecutive cycles, no loads -> memory written in order on the next 3 cycles, then empty=1.
REQ-034 SHALL verify: 4 stores with a load on every cycle, then a 5th store -> stall=1 for the 5th store until a load-free cycle pops the head.
REQ-035 SHALL verify: stores 0x10<-0xAAAA0001 and 0x10<-0xBBBB0002 buffered, then load 0x10 -> cpu_rdata=0xBBBB0002 in the same cycle, with mem_memread=1.
REQ-036 SHALL verify: store 0x12 buffered, then load 0x10 -> stall=1 until the 0x12 store drains, after which the load returns memory data.
REQ-037 SHALL verify: 3 stores buffered, then rst_n pulsed low mid-cycle -> empty=1 immediately and no memory write ever occurs for those stores.
REQ-038 SHALL verify: tail wraps past DEPTH-1 over 10 interleaved store/drain cycles -> memory contents match a reference model.
